can_axil_bridge: RTL and testbench

- Responder side of the CAN register-access handshake (wr_enable/wr_done/wr_busy, rd_enable/rd_done/rd_data) used by the CAN init and runtime control units.
- Converts each single-beat request into an AXI4-Lite master transaction toward the CAN controller IP register file.
- Returns completion pulses, read data and an error flag to the requester.

---
 rtl/can_axil_bridge.sv | 212 +++++++++++++++++++++
 tb/tb_can_axil_bridge.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_axil_bridge.sv
// Responder for the CAN register-access handshake, issuing one AXI4-Lite master beat per request.
// Optional watchdog enabled by defining CAN_AXIL_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module can_axil_bridge #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   wr_addr_in,
    input  logic [DATA_W-1:0]   wr_data_in,
    input  logic                wr_enable_in,
    output logic                wr_done_out,
    output logic                wr_busy_out,
    input  logic [ADDR_W-1:0]   rd_addr_in,
    input  logic                rd_enable_in,
    output logic                rd_done_out,
    output logic [DATA_W-1:0]   rd_data_out,
    output logic                err_out,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

    state_t              state_q, state_d;
    logic                aw_done_q, w_done_q;
    logic                is_rd_q, tmo_q, viol_q, busy_q;
    logic [1:0]          resp_q;
    logic                rd_pend_q, rd_pend_d, pend_set;
    logic [ADDR_W-1:0]   pend_addr_q;
    logic                start_wr, start_rd_new, start_rd_pend, tmo_fire;
    logic                done_err;
    logic                timed_out;

`ifdef CAN_AXIL_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] tmo_cnt_q;

    assign timed_out = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk) begin
        if (reset || state_q == IDLE || state_d != state_q)
            tmo_cnt_q <= '0;
        else
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
`else
    assign timed_out = 1'b0;
`endif

    assign m_axi_wstrb = '1;
    assign wr_busy_out = busy_q;

    always_comb begin
        state_d       = state_q;
        start_wr      = 1'b0;
        start_rd_new  = 1'b0;
        start_rd_pend = 1'b0;
        tmo_fire      = 1'b0;
        done_err      = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        wr_done_out   = 1'b0;
        rd_done_out   = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_enable_in) begin
                    state_d  = WR_REQ;
                    start_wr = 1'b1;
                end else if (rd_pend_q) begin
                    state_d       = RD_REQ;
                    start_rd_pend = 1'b1;
                end else if (rd_enable_in) begin
                    state_d      = RD_REQ;
                    start_rd_new = 1'b1;
                end
            end
            WR_REQ: begin
                m_axi_awvalid = !aw_done_q;
                m_axi_wvalid  = !w_done_q;
                // Each channel is complete once its flag is set or it handshakes this cycle.
                if ((aw_done_q || m_axi_awready) && (w_done_q || m_axi_wready)) begin
                    state_d = WR_RESP;
                end else if (timed_out) begin
                    state_d  = DONE;
                    tmo_fire = 1'b1;
                end
            end
            WR_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    state_d = DONE;
                end else if (timed_out) begin
                    state_d  = DONE;
                    tmo_fire = 1'b1;
                end
            end
            RD_REQ: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_d = RD_RESP;
                end else if (timed_out) begin
                    state_d  = DONE;
                    tmo_fire = 1'b1;
                end
            end
            RD_RESP: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    state_d = DONE;
                end else if (timed_out) begin
                    state_d  = DONE;
                    tmo_fire = 1'b1;
                end
            end
            DONE: begin
                wr_done_out = !is_rd_q;
                rd_done_out = is_rd_q;
                done_err    = (resp_q != 2'b00) || tmo_q;
                if (rd_pend_q) begin
                    state_d       = RD_REQ;
                    start_rd_pend = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        err_out = done_err || viol_q;
        // A read that is not launched now is parked, unless the single slot stays occupied.
        pend_set  = rd_enable_in && !start_rd_new && (!rd_pend_q || start_rd_pend);
        rd_pend_d = (rd_pend_q && !start_rd_pend) || pend_set;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            viol_q       <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            is_rd_q      <= 1'b0;
            tmo_q        <= 1'b0;
            resp_q       <= '0;
            rd_pend_q    <= 1'b0;
            pend_addr_q  <= '0;
            m_axi_awaddr <= '0;
            m_axi_wdata  <= '0;
            m_axi_araddr <= '0;
            rd_data_out  <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= (state_d != IDLE);
            viol_q    <= wr_enable_in && (state_q != IDLE);
            rd_pend_q <= rd_pend_d;
            if (pend_set)
                pend_addr_q <= rd_addr_in;
            if (start_wr) begin
                m_axi_awaddr <= wr_addr_in;
                m_axi_wdata  <= wr_data_in;
                is_rd_q      <= 1'b0;
            end
            if (start_rd_new) begin
                m_axi_araddr <= rd_addr_in;
                is_rd_q      <= 1'b1;
            end
            if (start_rd_pend) begin
                m_axi_araddr <= pend_addr_q;
                is_rd_q      <= 1'b1;
            end
            if (start_wr || start_rd_new || start_rd_pend) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                resp_q    <= '0;
                tmo_q     <= 1'b0;
            end else begin
                if (m_axi_awvalid && m_axi_awready)
                    aw_done_q <= 1'b1;
                if (m_axi_wvalid && m_axi_wready)
                    w_done_q <= 1'b1;
                if (m_axi_bready && m_axi_bvalid)
                    resp_q <= m_axi_bresp;
                if (m_axi_rready && m_axi_rvalid) begin
                    resp_q      <= m_axi_rresp;
                    rd_data_out <= m_axi_rdata;
                end
                if (tmo_fire)
                    tmo_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_can_axil_bridge.sv
// Self-checking bench for can_axil_bridge: vector table plus scoreboard of completions,
// with a configurable-latency AXI-Lite responder model.
module tb_can_axil_bridge;

    logic        sys_clk, reset;
    logic [7:0]  wr_addr_in, rd_addr_in;
    logic [31:0] wr_data_in;
    logic        wr_enable_in, rd_enable_in;
    logic        wr_done_out, wr_busy_out, rd_done_out, err_out;
    logic [31:0] rd_data_out;
    logic [7:0]  m_axi_awaddr, m_axi_araddr;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [31:0] m_axi_wdata, m_axi_rdata;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    can_axil_bridge #(.ADDR_W(8), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .sys_clk(sys_clk), .reset(reset),
        .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in), .wr_enable_in(wr_enable_in),
        .wr_done_out(wr_done_out), .wr_busy_out(wr_busy_out),
        .rd_addr_in(rd_addr_in), .rd_enable_in(rd_enable_in),
        .rd_done_out(rd_done_out), .rd_data_out(rd_data_out), .err_out(err_out),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Responder model configuration and observations.
    int          cfg_aw = 0, cfg_w = 0, cfg_b = 0, cfg_ar = 0, cfg_r = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = '0;
    int          aw_hs = 0, w_hs = 0, ar_hs = 0;
    logic [7:0]  got_awaddr, got_araddr;
    logic [31:0] got_wdata;
    logic [3:0]  got_wstrb;

    // Readies/valids are set at negedge; a handshake happens at the next posedge when both are high.
    initial begin
        int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
        forever begin
            @(negedge sys_clk);
            if (m_axi_awvalid) begin
                m_axi_awready = (aw_wait >= cfg_aw);
                if (m_axi_awready) begin aw_hs++; got_awaddr = m_axi_awaddr; end
                aw_wait++;
            end else begin m_axi_awready = 0; aw_wait = 0; end
            if (m_axi_wvalid) begin
                m_axi_wready = (w_wait >= cfg_w);
                if (m_axi_wready) begin w_hs++; got_wdata = m_axi_wdata; got_wstrb = m_axi_wstrb; end
                w_wait++;
            end else begin m_axi_wready = 0; w_wait = 0; end
            if (m_axi_bready) begin
                m_axi_bvalid = (b_wait >= cfg_b); m_axi_bresp = cfg_bresp; b_wait++;
            end else begin m_axi_bvalid = 0; b_wait = 0; end
            if (m_axi_arvalid) begin
                m_axi_arready = (ar_wait >= cfg_ar);
                if (m_axi_arready) begin ar_hs++; got_araddr = m_axi_araddr; end
                ar_wait++;
            end else begin m_axi_arready = 0; ar_wait = 0; end
            if (m_axi_rready) begin
                m_axi_rvalid = (r_wait >= cfg_r); m_axi_rresp = cfg_rresp; m_axi_rdata = cfg_rdata;
                r_wait++;
            end else begin m_axi_rvalid = 0; r_wait = 0; end
        end
    end

    typedef struct {
        bit          is_rd;
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    logic [31:0] last_rd = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (!reset && (wr_done_out || rd_done_out)) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", {30'd0, wr_done_out, rd_done_out}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_kind", {30'd0, wr_done_out, rd_done_out}, e.is_rd ? 32'd1 : 32'd2);
                    check("done_err", {31'd0, err_out}, {31'd0, e.err});
                    check("done_cycle", cyc, e.cyc);
                    check("rd_data", rd_data_out, e.rdata);
                end
            end
        end
    end

    task automatic push(input bit is_rd, input bit err, input int at);
        exp_t e;
        e.is_rd = is_rd; e.err = err; e.rdata = last_rd; e.cyc = at;
        sb.push_back(e);
    endtask

    // Caller is at a negedge; drive one request cycle and return at the following negedge.
    task automatic issue(input bit do_wr, input logic [7:0] wa, input logic [31:0] wd,
                         input bit do_rd, input logic [7:0] ra, output int c);
        c = cyc;
        wr_enable_in = do_wr; wr_addr_in = wa; wr_data_in = wd;
        rd_enable_in = do_rd; rd_addr_in = ra;
        @(negedge sys_clk);
        wr_enable_in = 0; rd_enable_in = 0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300 && sb.size() != 0; i++) begin
            @(negedge sys_clk);
            #1;
        end
        if (sb.size() != 0) begin
            check({"drain_timeout_", tag}, sb.size(), 0);
            sb.delete();
        end
        @(negedge sys_clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {23'd0, wr_done_out, wr_busy_out, rd_done_out, err_out, m_axi_awvalid,
                              m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 32'd0);
        check({tag, "_addr"}, {16'd0, m_axi_awaddr, m_axi_araddr}, 32'd0);
        check({tag, "_wdata"}, m_axi_wdata, 32'd0);
        check({tag, "_rdata"}, rd_data_out, 32'd0);
    endtask

    typedef struct {
        bit          is_rd;
        logic [7:0]  addr;
        logic [31:0] data;
        int          d0, d1, d2;   // write: aw/w/b delays; read: ar/r delays
        logic [1:0]  resp;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int c, h_aw, h_w, h_ar;
        vecs = '{
            '{0, 8'h04, 32'h0000_0002, 0, 0, 0, 2'b00, 0, 3},
            '{1, 8'h18, 32'h0000_0800, 0, 5, 0, 2'b00, 0, 8},
            '{0, 8'h10, 32'hDEAD_BEEF, 2, 0, 1, 2'b00, 0, 6},
            '{0, 8'h20, 32'h0000_0055, 0, 3, 0, 2'b10, 1, 6},
            '{1, 8'h30, 32'h0000_1234, 3, 0, 0, 2'b11, 1, 6},
            '{0, 8'h40, 32'h0000_0001, 1, 1, 0, 2'b00, 0, 4},
            '{1, 8'hFF, 32'hFFFF_FFFF, 0, 0, 0, 2'b01, 1, 3},
            '{0, 8'h08, 32'hA5A5_A5A5, 3, 1, 0, 2'b10, 1, 6}
        };
        reset = 1; wr_enable_in = 0; rd_enable_in = 0;
        wr_addr_in = 0; rd_addr_in = 0; wr_data_in = 0;
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("reset_init");
        reset = 0;
        @(negedge sys_clk);

        // Busy window around a minimum-latency write.
        check("busy_before", {31'd0, wr_busy_out}, 32'd0);
        push(0, 0, cyc + 3);
        issue(1, 8'h04, 32'h2, 0, 8'h00, c);
        check("busy_t1", {31'd0, wr_busy_out}, 32'd1);
        @(negedge sys_clk);
        check("busy_t2", {31'd0, wr_busy_out}, 32'd1);
        @(negedge sys_clk);
        check("busy_t3", {31'd0, wr_busy_out}, 32'd1);
        @(negedge sys_clk);
        check("busy_t4", {31'd0, wr_busy_out}, 32'd0);
        check("first_awaddr", {24'd0, got_awaddr}, 32'h04);
        check("first_wstrb", {28'd0, got_wstrb}, 32'hF);
        wait_drain("busy");

        for (int i = 0; i < 8; i++) begin
            h_aw = aw_hs; h_w = w_hs; h_ar = ar_hs;
            if (vecs[i].is_rd) begin
                cfg_ar = vecs[i].d0; cfg_r = vecs[i].d1;
                cfg_rdata = vecs[i].data; cfg_rresp = vecs[i].resp;
                last_rd = vecs[i].data;
            end else begin
                cfg_aw = vecs[i].d0; cfg_w = vecs[i].d1; cfg_b = vecs[i].d2;
                cfg_bresp = vecs[i].resp;
            end
            push(vecs[i].is_rd, vecs[i].exp_err, cyc + vecs[i].exp_lat);
            issue(!vecs[i].is_rd, vecs[i].addr, vecs[i].data, vecs[i].is_rd, vecs[i].addr, c);
            wait_drain("vec");
            if (vecs[i].is_rd) begin
                check("vec_ar_count", ar_hs - h_ar, 1);
                check("vec_araddr", {24'd0, got_araddr}, {24'd0, vecs[i].addr});
            end else begin
                check("vec_aw_count", aw_hs - h_aw, 1);
                check("vec_w_count", w_hs - h_w, 1);
                check("vec_awaddr", {24'd0, got_awaddr}, {24'd0, vecs[i].addr});
                check("vec_wdata", got_wdata, vecs[i].data);
                check("vec_wstrb", {28'd0, got_wstrb}, 32'hF);
            end
            check("vec_rd_data_hold", rd_data_out, last_rd);
        end
        cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_ar = 0; cfg_r = 0;
        cfg_bresp = 0; cfg_rresp = 0;

        // Simultaneous write and read: write first, read follows DONE with no idle gap.
        cfg_rdata = 32'h0000_0777;
        push(0, 0, cyc + 3);
        last_rd = 32'h0000_0777;
        push(1, 0, cyc + 6);
        issue(1, 8'h08, 32'h1, 1, 8'h18, c);
        repeat (3) @(negedge sys_clk);
        check("both_busy_gap", {31'd0, wr_busy_out}, 32'd1);
        check("both_arvalid", {31'd0, m_axi_arvalid}, 32'd1);
        wait_drain("both");
        check("both_araddr", {24'd0, got_araddr}, 32'h18);
        check("both_awaddr", {24'd0, got_awaddr}, 32'h08);

        // Write while busy is dropped and flagged.
        cfg_r = 5; cfg_rdata = 32'h0000_0ABC; last_rd = 32'h0000_0ABC;
        h_aw = aw_hs;
        push(1, 0, cyc + 8);
        issue(0, 8'h00, 32'h0, 1, 8'h24, c);
        @(negedge sys_clk);
        wr_enable_in = 1; wr_addr_in = 8'h50; wr_data_in = 32'h99;
        @(negedge sys_clk);
        wr_enable_in = 0;
        check("viol_err", {31'd0, err_out}, 32'd1);
        check("viol_no_done", {31'd0, wr_done_out}, 32'd0);
        wait_drain("viol");
        check("viol_no_write", aw_hs - h_aw, 0);
        cfg_r = 0;

        // Reset while waiting for the write response.
        cfg_b = 20;
        issue(1, 8'h0C, 32'h3, 0, 8'h00, c);
        @(negedge sys_clk);
        check("pre_reset_bready", {31'd0, m_axi_bready}, 32'd1);
        reset = 1;
        @(negedge sys_clk);
        check_reset_outputs("reset_mid");
        reset = 0;
        cfg_b = 0; last_rd = '0;
        @(negedge sys_clk);
        cfg_rdata = 32'h0000_4321; last_rd = 32'h0000_4321;
        push(1, 0, cyc + 3);
        issue(0, 8'h00, 32'h0, 1, 8'h2C, c);
        wait_drain("post_reset");
        check("post_reset_araddr", {24'd0, got_araddr}, 32'h2C);

`ifdef CAN_AXIL_TIMEOUT_EN
        // Stuck arready: watchdog ends the read with an error, data unchanged.
        cfg_ar = 1000;
        push(1, 1, cyc + 17);
        issue(0, 8'h00, 32'h0, 1, 8'h34, c);
        repeat (15) @(negedge sys_clk);
        check("tmo_arvalid_held", {31'd0, m_axi_arvalid}, 32'd1);
        @(negedge sys_clk);
        check("tmo_arvalid_drop", {31'd0, m_axi_arvalid}, 32'd0);
        wait_drain("timeout");
        cfg_ar = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit exceeded");
    end

endmodule
